// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, one parity bit, stop.
// Presents each byte with a one-cycle RXvalid strobe and held parity/framing error flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RXdataIn,
  output logic [7:0] RXdata,
  output logic       RXvalid,
  output logic       parityErr,
  output logic       frameErr,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_LIM = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LIM = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] clk_cnt;
  logic [CW-1:0] limit;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          sync1;
  logic          sync2;
  logic          rxs;
  logic          armed;
  logic          perr;
  logic          sample;

  assign rxs       = sync2;
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  // The start bit is sampled at its middle; every later bit one full period on.
  always_comb begin
    limit  = (state == ST_START) ? HALF_LIM : FULL_LIM;
    sample = (state != ST_IDLE) && (clk_cnt == limit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      armed     <= 1'b1;
      perr      <= 1'b0;
      RXdata    <= '0;
      RXvalid   <= 1'b0;
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      sync1   <= RXdataIn;
      sync2   <= sync1;
      RXvalid <= 1'b0;

      if (state == ST_IDLE || sample) clk_cnt <= '0;
      else                            clk_cnt <= clk_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          if (rxs) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed <= 1'b0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (sample) state <= rxs ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (sample) begin
            shift   <= {rxs, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (sample) begin
            perr  <= ((^shift) ^ rxs) != PARITY_ODD;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Leaving at mid stop bit; a low stop leaves IDLE unarmed so a held break gives one frame.
          if (sample) begin
            RXdata    <= shift;
            parityErr <= perr;
            frameErr  <= ~rxs;
            RXvalid   <= 1'b1;
            armed     <= rxs;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: even- and odd-parity instances share one serial line;
// expected frames are queued at stimulus time and compared by per-instance monitors.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data_e, rx_data_o;
  logic       valid_e, valid_o;
  logic       perr_e, perr_o;
  logic       ferr_e, ferr_o;
  logic       busy_e, busy_o;
  logic [2:0] st_e, st_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  // Expected {frameErr, parityErr, RXdata} per instance.
  logic [9:0] exp_q[$];
  logic [9:0] exp_q_odd[$];
  int valid_cyc_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .reset(reset), .RXdataIn(rx), .RXdata(rx_data_e), .RXvalid(valid_e),
    .parityErr(perr_e), .frameErr(ferr_e), .busy(busy_e), .state_dbg(st_e)
  );

  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .RXdataIn(rx), .RXdata(rx_data_o), .RXvalid(valid_o),
    .parityErr(perr_o), .frameErr(ferr_o), .busy(busy_o), .state_dbg(st_o)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    if (valid_e) begin
      valid_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL even_unexpected_strobe act=%0h exp=none", {ferr_e, perr_e, rx_data_e});
      end else begin
        check("even_frame", {22'd0, ferr_e, perr_e, rx_data_e}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (valid_o) begin
      if (exp_q_odd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL odd_unexpected_strobe act=%0h exp=none", {ferr_o, perr_o, rx_data_o});
      end else begin
        check("odd_frame", {22'd0, ferr_o, perr_o, rx_data_o}, {22'd0, exp_q_odd.pop_front()});
      end
    end
  end

  // Driver tasks
  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                            input logic pe_even);
    exp_q.push_back({~stop, pe_even, d});
    exp_q_odd.push_back({~stop, ~pe_even, d});
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(stop);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rxdata"}, {24'd0, rx_data_e}, 32'd0);
    check({tag, "_rxvalid"}, {31'd0, valid_e}, 32'd0);
    check({tag, "_parityerr"}, {31'd0, perr_e}, 32'd0);
    check({tag, "_frameerr"}, {31'd0, ferr_e}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_e}, 32'd0);
    check({tag, "_state"}, {29'd0, st_e}, 32'd0);
  endtask

  int lat;
  int busy_cnt;

  initial begin
    rx    = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    idle_bits(2);

    // 1: clean frame 0xA5, even parity bit 0
    valid_cyc_q.delete();
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("t1_busy_after", {31'd0, busy_e}, 32'd0);
    check("t1_strobes", valid_cyc_q.size(), 32'd1);
    if (valid_cyc_q.size() > 0) begin
      lat = valid_cyc_q[0] - start_cyc;
      check("t1_latency_in_169_171", {31'd0, (lat >= 169 && lat <= 171)}, 32'd1);
      if (lat < 169 || lat > 171) $display("  latency measured %0d", lat);
    end
    idle_bits(1);

    // 2: 0x01 with parity 0 -> even instance flags, odd instance does not
    send_frame(8'h01, 1'b0, 1'b1, 1'b1);
    idle_bits(1);

    // 3: 0x3C with stop 0 then a long break: exactly one strobe
    valid_cyc_q.delete();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    check("t3_break_strobes", valid_cyc_q.size(), 32'd1);
    check("t3_break_busy", {31'd0, busy_e}, 32'd0);
    idle_bits(2);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    idle_bits(1);
    check("t3_after_break_strobes", valid_cyc_q.size(), 32'd2);

    // 4: short low glitch on idle line
    valid_cyc_q.delete();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_e) busy_cnt++;
    end
    check("t4_start_entered", {31'd0, busy_cnt > 0}, 32'd1);
    check("t4_busy_short", {31'd0, busy_cnt < CPB / 2 + 3}, 32'd1);
    check("t4_no_strobe", valid_cyc_q.size(), 32'd0);
    idle_bits(1);

    // 5: three frames with zero idle gap
    valid_cyc_q.delete();
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    send_frame(8'hAA, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    idle_bits(1);
    check("t5_strobes", valid_cyc_q.size(), 32'd3);
    if (valid_cyc_q.size() == 3) begin
      check("t5_gap1", valid_cyc_q[1] - valid_cyc_q[0], 32'd176);
      check("t5_gap2", valid_cyc_q[2] - valid_cyc_q[1], 32'd176);
    end

    // 6: reset during data bit 4 of 0x77, then a clean 0x12
    valid_cyc_q.delete();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1 & (8'h77 >> i));
    rx = 1'b1;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("t6_reset");
    reset = 1'b0;
    idle_bits(2);
    check("t6_no_strobe", valid_cyc_q.size(), 32'd0);
    send_frame(8'h12, 1'b0, 1'b1, 1'b0);
    idle_bits(2);
    check("t6_strobes", valid_cyc_q.size(), 32'd1);

    // Final report
    check("even_queue_drained", exp_q.size(), 32'd0);
    check("odd_queue_drained", exp_q_odd.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
